shared_mem_arbiter: RTL and testbench
=====================================

// Module: shared_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory (1-cycle read latency) between the
//  fetch-stage instruction port (I) and the memory-stage load/store port (D).
//  Data wins contention by default; a starvation guard forces a fetch grant
//  after MAX_WAIT denied cycles. Routes read data back to the owner and drives
//  PC_En so the program counter holds while fetch is not granted.
// PARAMETERS
//  ADDR_W    32  width of all address ports
//  MAX_WAIT  4   consecutive denied I cycles before I gets priority (1..15)
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       asynchronous, active-high reset
//  I_Req      in   1       fetch read request; held until granted
//  I_Addr     in   ADDR_W  fetch byte address
//  I_Gnt      out  1       fetch request accepted this cycle
//  I_RValid   out  1       I_RData valid (cycle after I_Gnt)
//  I_RData    out  32      fetch read data
//  D_Req      in   1       load/store request; held until granted
//  D_We       in   1       1 = store, 0 = load
//  D_Be       in   4       store byte enables
//  D_Addr     in   ADDR_W  load/store byte address
//  D_WData    in   32      store data
//  D_Gnt      out  1       load/store accepted this cycle
//  D_RValid   out  1       D_RData valid (cycle after a load grant)
//  D_RData    out  32      load read data
//  Mem_En     out  1       memory access this cycle
//  Mem_We     out  1       memory write strobe
//  Mem_Be     out  4       memory byte enables
//  Mem_Addr   out  ADDR_W  memory byte address
//  Mem_WData  out  32      memory write data
//  Mem_RData  in   32      memory read data, valid cycle after Mem_En & ~Mem_We
//  PC_En      out  1       program-counter enable, = ~I_Req | I_Gnt
// BEHAVIOUR
//  - Grant is combinational from requests + registered state; at most one
//    grant per cycle; a grant is issued only when the corresponding Req is high.
//  - Only D: D_Gnt=1. Only I: I_Gnt=1. Both: I_Gnt=1 iff Wait_Cnt==MAX_WAIT,
//    otherwise D_Gnt=1.
//  - Wait_Cnt (4b, reg): on a cycle with I_Req & ~I_Gnt, increments and
//    saturates at MAX_WAIT; on I_Gnt or ~I_Req, cleared to 0.
//  - Memory drive: I grant -> Mem_En=1, Mem_We=0, Mem_Be=4'hF,
//    Mem_Addr=I_Addr. D grant -> Mem_En=1, Mem_We=D_We, Mem_Be=D_Be
//    (4'hF for loads), Mem_Addr=D_Addr, Mem_WData=D_WData. No grant ->
//    Mem_En=0, Mem_We=0, Mem_Be=0, Mem_Addr=0, Mem_WData=0.
//  - Owner register (NONE/I/D), updated every edge: I on I grant, D on
//    D load grant, NONE otherwise (incl. store grant).
//  - I_RValid=(Owner==I), D_RValid=(Owner==D); both RData outputs pass
//    Mem_RData, qualified only by their RValid. Read latency is exactly 1 cycle.
//  - Back-to-back grants every cycle are allowed; one response per grant.
//  - Stores complete at grant: no RValid is produced.
//  - Addresses are passed through unmodified; alignment is the memory's concern.
//  - Reset (async assert, sync release): Owner=NONE, Wait_Cnt=0, so
//    I_RValid=D_RValid=0. Reset mid-access discards the pending response:
//    no RValid appears after reset is released.
//  - Outputs with combinational paths from requests: I_Gnt, D_Gnt, PC_En,
//    and Mem_*.
// TESTING
//  1. I_Req=1, I_Addr=0x10, D_Req=0 -> I_Gnt=1, Mem_Addr=0x10, PC_En=1; next cycle I_RValid=1, I_RData=Mem_RData.
//  2. D load 0x200 with I_Req=1 -> D_Gnt=1, PC_En=0; next cycle D_RValid=1, I_RValid=0.
//  3. D_Req held 10 cycles with I_Req=1, MAX_WAIT=4 -> D granted cycles 0-3, I granted cycle 4, D again cycle 5.
//  4. D store Be=4'b0011 -> Mem_We=1, Mem_Be=4'b0011 for one cycle; no D_RValid follows.
//  5. Assert RST the cycle after an I grant -> I_RValid=0 during and after reset; Wait_Cnt=0.
//  6. Alternate I/D grants every cycle -> each response valid exactly 1 cycle later, to the correct port.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency memory between the fetch (I) and load/store (D) ports.
// D wins contention until I has been denied MAX_WAIT cycles in a row; read data is steered to the owner.
module shared_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_Req,
  input  logic [ADDR_W-1:0] I_Addr,
  output logic              I_Gnt,
  output logic              I_RValid,
  output logic [31:0]       I_RData,
  input  logic              D_Req,
  input  logic              D_We,
  input  logic [3:0]        D_Be,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [31:0]       D_WData,
  output logic              D_Gnt,
  output logic              D_RValid,
  output logic [31:0]       D_RData,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [3:0]        Mem_Be,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData,
  output logic              PC_En
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  owner_t     owner_q, owner_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       i_gnt, d_gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_q    <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    owner_d    = OWN_NONE;
    wait_cnt_d = '0;
    Mem_En     = 1'b0;
    Mem_We     = 1'b0;
    Mem_Be     = 4'h0;
    Mem_Addr   = '0;
    Mem_WData  = '0;

    if (I_Req && (!D_Req || wait_cnt_q == WAIT_LIM)) begin
      i_gnt = 1'b1;
    end else if (D_Req) begin
      d_gnt = 1'b1;
    end

    if (i_gnt) begin
      Mem_En   = 1'b1;
      Mem_Be   = 4'hF;
      Mem_Addr = I_Addr;
      owner_d  = OWN_I;
    end else if (d_gnt) begin
      Mem_En    = 1'b1;
      Mem_We    = D_We;
      Mem_Be    = D_We ? D_Be : 4'hF;
      Mem_Addr  = D_Addr;
      Mem_WData = D_WData;
      // A store finishes at grant, so only loads expect a response next cycle
      owner_d   = D_We ? OWN_NONE : OWN_D;
    end

    if (I_Req && !i_gnt) begin
      wait_cnt_d = (wait_cnt_q >= WAIT_LIM) ? WAIT_LIM : wait_cnt_q + 4'd1;
    end
  end

  assign I_Gnt    = i_gnt;
  assign D_Gnt    = d_gnt;
  assign PC_En    = ~I_Req | i_gnt;
  assign I_RValid = (owner_q == OWN_I);
  assign D_RValid = (owner_q == OWN_D);
  assign I_RData  = I_RValid ? Mem_RData : 32'h0;
  assign D_RData  = D_RValid ? Mem_RData : 32'h0;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a request-level model predicts grants, memory drive
// and responses every cycle, and literal expectations pin the documented scenarios.
module tb_shared_mem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              I_Req;
  logic [ADDR_W-1:0] I_Addr;
  logic              I_Gnt, I_RValid;
  logic [31:0]       I_RData;
  logic              D_Req, D_We;
  logic [3:0]        D_Be;
  logic [ADDR_W-1:0] D_Addr;
  logic [31:0]       D_WData;
  logic              D_Gnt, D_RValid;
  logic [31:0]       D_RData;
  logic              Mem_En, Mem_We;
  logic [3:0]        Mem_Be;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       Mem_WData;
  logic [31:0]       Mem_RData = 32'h0;
  logic              PC_En;

  int total = 0;
  int bad   = 0;

  shared_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(clk), .RST(rst),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Gnt(I_Gnt), .I_RValid(I_RValid), .I_RData(I_RData),
    .D_Req(D_Req), .D_We(D_We), .D_Be(D_Be), .D_Addr(D_Addr), .D_WData(D_WData),
    .D_Gnt(D_Gnt), .D_RValid(D_RValid), .D_RData(D_RData),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Be(Mem_Be), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .PC_En(PC_En)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory stand-in: 1-cycle read latency, content derived from address
  always @(posedge clk) begin
    if (Mem_En && !Mem_We) Mem_RData <= memval(Mem_Addr);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Request-level model: how long I has starved, and which port is owed a response
  int          m_starve;
  int          m_pend;   // 0 none, 1 fetch, 2 load
  logic [31:0] m_paddr;

  function automatic logic m_i_wins();
    return I_Req && (!D_Req || m_starve == MAX_WAIT);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_starve = 0;
      m_pend   = 0;
      m_paddr  = 32'h0;
    end else begin
      if (m_i_wins()) begin
        m_pend  = 1;
        m_paddr = I_Addr;
      end else if (D_Req && !D_We) begin
        m_pend  = 2;
        m_paddr = D_Addr;
      end else begin
        m_pend = 0;
      end
      if (I_Req && !m_i_wins()) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      else m_starve = 0;
    end
  end

  logic run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      logic eig, edg;
      eig = m_i_wins();
      edg = D_Req && !eig;
      chk("i_gnt", I_Gnt, eig);
      chk("d_gnt", D_Gnt, edg);
      chk("pc_en", PC_En, !I_Req || eig);
      chk("mem_en", Mem_En, eig || edg);
      chk("mem_we", Mem_We, edg && D_We);
      chk("mem_be", Mem_Be, eig ? 4'hF : edg ? (D_We ? D_Be : 4'hF) : 4'h0);
      chk("mem_addr", Mem_Addr, eig ? I_Addr : edg ? D_Addr : '0);
      if (!eig) chk("mem_wdata", Mem_WData, edg ? D_WData : 32'h0);
      chk("i_rvalid", I_RValid, m_pend == 1);
      chk("d_rvalid", D_RValid, m_pend == 2);
      chk("i_rdata", I_RData, (m_pend == 1) ? memval(m_paddr) : 32'h0);
      chk("d_rdata", D_RData, (m_pend == 2) ? memval(m_paddr) : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    I_Req = ir; I_Addr = ia; D_Req = dr; D_We = dw; D_Be = be; D_Addr = da; D_WData = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [9:0] pat;
    logic [4:0] pat5;
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_i_rvalid", I_RValid, 1'b0);
    chk("rst_d_rvalid", D_RValid, 1'b0);
    chk("rst_mem_en", Mem_En, 1'b0);
    step();
    rst = 1'b0;
    run_cmp = 1'b1;

    // Fetch alone
    step(); drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_i_gnt", I_Gnt, 1'b1);
    chk("t1_addr", Mem_Addr, 32'h10);
    chk("t1_pc_en", PC_En, 1'b1);
    step(); idle();
    @(negedge clk);
    chk("t1_i_rvalid", I_RValid, 1'b1);
    chk("t1_i_rdata", I_RData, memval(32'h10));

    // Load beats a waiting fetch
    step(); drive(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    @(negedge clk);
    chk("t2_d_gnt", D_Gnt, 1'b1);
    chk("t2_pc_en", PC_En, 1'b0);
    chk("t2_addr", Mem_Addr, 32'h200);
    step(); drive(1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t2_d_rvalid", D_RValid, 1'b1);
    chk("t2_i_rvalid", I_RValid, 1'b0);
    chk("t2_d_rdata", D_RData, memval(32'h200));
    step(); idle();

    // Starvation guard: fetch forced through after MAX_WAIT denials
    step(); drive(1'b1, 32'h80, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = I_Gnt;
      if (i < 9) step();
    end
    chk("t3_pattern", pat, 10'b10_0001_0000);
    step(); idle();

    // Store: byte enables pass, no response
    step(); drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h400, 32'hDEADBEEF);
    @(negedge clk);
    chk("t4_we", Mem_We, 1'b1);
    chk("t4_be", Mem_Be, 4'b0011);
    chk("t4_wdata", Mem_WData, 32'hDEADBEEF);
    step(); idle();
    @(negedge clk);
    chk("t4_no_rvalid", D_RValid, 1'b0);

    // Reset right after a fetch grant discards the response
    step(); drive(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_i_gnt", I_Gnt, 1'b1);
    step(); rst = 1'b1; idle();
    @(negedge clk);
    chk("t5_rvalid_in_rst", I_RValid, 1'b0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_after", I_RValid, 1'b0);
    step(); drive(1'b1, 32'h24, 1'b1, 1'b0, 4'h0, 32'h500, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat5[i] = I_Gnt;
      if (i < 4) step();
    end
    chk("t5_wait_cleared", pat5, 5'b10000);
    step(); idle();

    // Alternating fetch and load grants
    for (int k = 0; k < 8; k++) begin
      step();
      if (k % 2 == 0) drive(1'b1, 32'h1000 + 32'(k * 4), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      else drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h2000 + 32'(k * 4), 32'h0);
      @(negedge clk);
      if (k > 0) begin
        chk("t6_i_rvalid", I_RValid, (k % 2) == 1);
        chk("t6_d_rvalid", D_RValid, (k % 2) == 0);
      end
    end
    step(); idle();
    @(negedge clk);
    chk("t6_last_d_rvalid", D_RValid, 1'b1);
    chk("t6_last_d_rdata", D_RData, memval(32'h2000 + 32'd28));
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
